// File: rtl/spi_pkg.sv
// Shared types for the SPI serial-clock engine: FSM state, latched mode, length saturation.
// Latency: n/a (types and pure function only).
// Backpressure: n/a.
package spi_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef enum logic [0:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN
    } spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // A zero or oversized length means "longest character supported".
    function automatic int unsigned sat_char_len(input int unsigned len, input int unsigned max_len);
        return (len == 0 || len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK prescaler: ticks once every div_val+1 enabled cycles.
// Latency: tick is combinational on the current count; first tick div_val cycles after clear drops.
// Backpressure: none; clear has priority over en.
module spi_clk_div #(
    parameter int DIV_W = 8
) (
    input  logic             pclk,
    input  logic             presetn,
    input  logic             clear,
    input  logic             en,
    input  logic [DIV_W-1:0] div_val,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = en && (cnt == div_val);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_sclk_engine.sv
// SPI serial-clock engine: divided SCLK, edge counting and per-edge sample/shift strobes.
// Latency: busy one cycle after start; each edge's sclk/edge_cnt/strobe/done appear together.
// Backpressure: start ignored while busy; abort returns to idle next cycle and beats an edge.
module spi_sclk_engine
    import spi_pkg::*;
#(
    parameter int DIV_W   = 8,
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = $clog2(2 * MAX_LEN + 1)
) (
    input  logic             pclk,
    input  logic             presetn,
    input  logic             start,
    input  logic             abort,
    input  logic [DIV_W-1:0] clk_div,
    input  logic [LEN_W-1:0] char_len,
    input  logic             cpol,
    input  logic             cpha,
    output logic             sclk,
    output logic             sample_stb,
    output logic             shift_stb,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             even,
    output logic             busy,
    output logic             done
);

    spi_state_t       state;
    spi_mode_t        mode_q;
    logic [DIV_W-1:0] div_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_sat;
    logic [CNT_W-1:0] next_cnt;
    logic [CNT_W-1:0] last_cnt;
    logic             running;
    logic             tick;
    logic             lead;
    logic             do_sample;
    logic             do_shift;

    assign running  = (state == RUN);
    assign len_sat  = LEN_W'(sat_char_len(32'(char_len), MAX_LEN));
    assign next_cnt = edge_cnt + CNT_W'(1);
    assign last_cnt = CNT_W'(len_q) << 1;
    assign lead     = next_cnt[0];
    assign even     = ~edge_cnt[0];

    // The final trailing edge never launches a new MOSI bit in mode cpha=0.
    assign do_sample = mode_q.cpha ? !lead : lead;
    assign do_shift  = mode_q.cpha ? lead : (!lead && (next_cnt != last_cnt));

    spi_clk_div #(.DIV_W(DIV_W)) u_clk_div (
        .pclk    (pclk),
        .presetn (presetn),
        .clear   (!running),
        .en      (running),
        .div_val (div_q),
        .tick    (tick)
    );

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state       <= IDLE;
            sclk        <= 1'b0;
            edge_cnt    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sample_stb  <= 1'b0;
            shift_stb   <= 1'b0;
            div_q       <= '0;
            len_q       <= '0;
            mode_q.cpol <= 1'b0;
            mode_q.cpha <= 1'b0;
        end else begin
            done       <= 1'b0;
            sample_stb <= 1'b0;
            shift_stb  <= 1'b0;
            case (state)
                IDLE: begin
                    sclk <= cpol;
                    if (start && !abort) begin
                        state       <= RUN;
                        busy        <= 1'b1;
                        edge_cnt    <= '0;
                        div_q       <= clk_div;
                        len_q       <= len_sat;
                        mode_q.cpol <= cpol;
                        mode_q.cpha <= cpha;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        sclk  <= mode_q.cpol;
                    end else if (tick) begin
                        sclk       <= ~sclk;
                        edge_cnt   <= next_cnt;
                        sample_stb <= do_sample;
                        shift_stb  <= do_shift;
                        if (next_cnt == last_cnt) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_sclk_engine.sv
// Self-checking bench for spi_sclk_engine: directed and random characters against a timing-formula model.
module tb_spi_sclk_engine;

    localparam int DIV_W   = 8;
    localparam int MAX_LEN = 32;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int CNT_W   = $clog2(2 * MAX_LEN + 1);

    logic             pclk = 1'b0;
    logic             presetn;
    logic             start;
    logic             abort;
    logic [DIV_W-1:0] clk_div;
    logic [LEN_W-1:0] char_len;
    logic             cpol;
    logic             cpha;
    logic             sclk;
    logic             sample_stb;
    logic             shift_stb;
    logic [CNT_W-1:0] edge_cnt;
    logic             even;
    logic             busy;
    logic             done;

    int total = 0;
    int bad   = 0;

    spi_sclk_engine #(.DIV_W(DIV_W), .MAX_LEN(MAX_LEN)) dut (
        .pclk       (pclk),
        .presetn    (presetn),
        .start      (start),
        .abort      (abort),
        .clk_div    (clk_div),
        .char_len   (char_len),
        .cpol       (cpol),
        .cpha       (cpha),
        .sclk       (sclk),
        .sample_stb (sample_stb),
        .shift_stb  (shift_stb),
        .edge_cnt   (edge_cnt),
        .even       (even),
        .busy       (busy),
        .done       (done)
    );

    always #5 pclk = ~pclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int cyc, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // One character. Edge k becomes visible k*(d+1)+1 cycles after the start cycle;
    // an abort driven in the cycle edge A shows up freezes everything from the cycle after next.
    task automatic run_char(input int d, input int l_in, input logic pol, input logic pha,
                            input int abort_at, input bit disturb);
        int  l, last, per, ta, t_end, n, raw;
        bit  aborted, edge_here, lead;
        logic e_sample, e_shift;
        l    = (l_in == 0 || l_in > MAX_LEN) ? MAX_LEN : l_in;
        last = 2 * l;
        per  = d + 1;
        ta   = 1 + abort_at * per + 1;
        t_end = (abort_at > 0) ? ta + 2 : 1 + last * per + 2;

        @(posedge pclk); #1;
        cpol = pol; cpha = pha; clk_div = DIV_W'(d); char_len = LEN_W'(l_in);
        @(posedge pclk); #1;
        chk("idle_sclk", 0, 32'(sclk), 32'(pol));
        chk("idle_busy", 0, 32'(busy), 32'(0));
        start = 1'b1;

        for (int c = 1; c <= t_end; c++) begin
            @(posedge pclk); #1;
            start = 1'b0;
            abort = 1'b0;
            aborted = (abort_at > 0) && (c >= ta);
            raw = (c - 1) / per;
            n   = (raw > last) ? last : raw;
            if (aborted) n = abort_at;
            edge_here = !aborted && ((c - 1) % per == 0) && raw >= 1 && raw <= last;
            lead     = (n % 2) == 1;
            e_sample = edge_here && (pha ? !lead : lead);
            e_shift  = edge_here && (pha ? lead : (!lead && n != last));

            chk("edge_cnt", c, 32'(edge_cnt), 32'(n));
            chk("sclk", c, 32'(sclk), aborted ? 32'(pol) : 32'(pol ^ lead));
            chk("busy", c, 32'(busy), 32'(!aborted && n < last));
            chk("done", c, 32'(done), 32'(edge_here && n == last));
            chk("sample_stb", c, 32'(sample_stb), 32'(e_sample));
            chk("shift_stb", c, 32'(shift_stb), 32'(e_shift));
            chk("even", c, 32'(even), 32'(!lead));

            if (abort_at > 0 && c == 1 + abort_at * per) abort = 1'b1;
            if (disturb && c == 3) begin
                start    = 1'b1;
                clk_div  = DIV_W'(7);
                char_len = LEN_W'(3);
                cpha     = ~pha;
            end
        end
    endtask

    initial begin
        int d, l, ab;
        logic p, h;
        presetn = 1'b0; start = 1'b0; abort = 1'b0;
        clk_div = '0; char_len = '0; cpol = 1'b0; cpha = 1'b0;
        #12;
        chk("rst_sclk", 0, 32'(sclk), 32'(0));
        chk("rst_busy", 0, 32'(busy), 32'(0));
        chk("rst_edge_cnt", 0, 32'(edge_cnt), 32'(0));
        chk("rst_even", 0, 32'(even), 32'(1));
        chk("rst_strobes", 0, 32'({done, sample_stb, shift_stb}), 32'(0));
        @(negedge pclk);
        presetn = 1'b1;

        run_char(0, 8, 1'b0, 1'b0, 0, 1'b0);
        run_char(3, 4, 1'b1, 1'b1, 0, 1'b0);
        run_char(0, 0, 1'b0, 1'b1, 0, 1'b0);
        run_char(1, MAX_LEN + 5, 1'b1, 1'b0, 0, 1'b0);
        run_char(0, 8, 1'b0, 1'b0, 5, 1'b0);
        run_char(2, 8, 1'b1, 1'b0, 0, 1'b0);
        run_char(1, 8, 1'b0, 1'b1, 0, 1'b1);
        run_char(7, 3, 1'b0, 1'b1, 0, 1'b0);

        // start together with abort in idle must not launch a character
        @(posedge pclk); #1;
        start = 1'b1; abort = 1'b1;
        @(posedge pclk); #1;
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", 0, 32'(busy), 32'(0));
        @(posedge pclk); #1;
        chk("start_abort_busy2", 1, 32'(busy), 32'(0));

        for (int i = 0; i < 20; i++) begin
            d  = int'($urandom_range(0, 3));
            l  = int'($urandom_range(1, 10));
            if (i % 7 == 3) l = 0;
            if (i % 7 == 5) l = MAX_LEN + int'($urandom_range(1, 20));
            p  = 1'($urandom);
            h  = 1'($urandom);
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2 * ((l == 0 || l > MAX_LEN) ? MAX_LEN : l) - 1)) : 0;
            run_char(d, l, p, h, ab, 1'b0);
        end

        // asynchronous reset in the middle of a character
        @(posedge pclk); #1;
        cpol = 1'b0; cpha = 1'b0; clk_div = DIV_W'(1); char_len = LEN_W'(8);
        start = 1'b1;
        @(posedge pclk); #1;
        start = 1'b0;
        repeat (8) @(posedge pclk);
        #3;
        chk("pre_rst_busy", 0, 32'(busy), 32'(1));
        presetn = 1'b0;
        #1;
        chk("arst_sclk", 0, 32'(sclk), 32'(0));
        chk("arst_busy", 0, 32'(busy), 32'(0));
        chk("arst_edge_cnt", 0, 32'(edge_cnt), 32'(0));
        chk("arst_even", 0, 32'(even), 32'(1));
        @(posedge pclk); #1;
        presetn = 1'b1;
        repeat (3) begin
            @(posedge pclk); #1;
            chk("post_rst_busy", 0, 32'(busy), 32'(0));
            chk("post_rst_edge_cnt", 0, 32'(edge_cnt), 32'(0));
            chk("post_rst_sclk", 0, 32'(sclk), 32'(0));
        end
        run_char(0, 2, 1'b1, 1'b0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_sclk_engine.md
Name: spi_sclk_engine

Overview:
Parametrised SPI serial-clock engine: the next generation of the SPI edge counter. Generates SCLK from pclk through a programmable divider and counts SCLK edges over a programmable character length. Supports all four CPOL/CPHA modes and emits per-edge sample and shift strobes. Sits between the SPI control registers and the shift register, and drives SCLK to the pad.

Parameters:
DIV_W, 8, width of clk_div; SCLK half-period is clk_div+1 pclk cycles
MAX_LEN, 32, maximum character length in bits
LEN_W, $clog2(MAX_LEN+1), width of char_len
CNT_W, $clog2(2*MAX_LEN+1), width of edge_cnt

Ports:
pclk  in  1  system clock
presetn  in  1  reset, asynchronous, active-low
start  in  1  single-cycle request to begin a character; ignored while busy
abort  in  1  synchronous stop; returns to idle without done
clk_div  in  DIV_W  half-period minus one, latched on start
char_len  in  LEN_W  bits per character, latched on start; 0 or values above MAX_LEN are treated as MAX_LEN
cpol  in  1  idle SCLK level
cpha  in  1  0 = sample leading edge, 1 = sample trailing edge (latched on start)
sclk  out  1  serial clock
sample_stb  out  1  one-cycle pulse: shift register samples MISO
shift_stb  out  1  one-cycle pulse: shift register drives the next MOSI bit
edge_cnt  out  CNT_W  number of SCLK edges produced in the current character
even  out  1  ~edge_cnt[0]
busy  out  1  character in progress
done  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset: sclk=0, edge_cnt=0, busy=0, done=0, sample_stb=0, shift_stb=0, even=1, FSM=IDLE, divider counter=0.
- FSM states are IDLE and RUN.
- IDLE:
  - sclk is registered from the live cpol every cycle.
  - start=1 (with abort=0) -> RUN next cycle.
  - On that transition: latch clk_div, len (with saturation), cpha and cpol; clear edge_cnt and the divider; set busy=1.
- RUN:
  - The divider increments each cycle.
  - When divider==D (latched clk_div), an edge event occurs and the divider returns to 0.
  - Edge event registered effects, all visible together in the next cycle:
    - sclk toggles.
    - edge_cnt increments.
    - Strobes are set per the mapping below.
  - The result is a half-period of D+1 cycles. With D=0, sclk toggles every cycle.
- Edge index k=1..2*len (value of edge_cnt after the increment). Odd k is a leading edge; even k is a trailing edge.
  - cpha=0: sample_stb on odd k; shift_stb on even k with k<2*len.
  - cpha=1: shift_stb on odd k; sample_stb on even k.
  - sample_stb and shift_stb are never asserted in the same cycle.
- Completion: at the edge with k==2*len, done=1 and busy=0 in the same cycle that sclk, edge_cnt and the strobe become visible. The FSM then enters IDLE; sclk already equals the latched cpol.
- edge_cnt holds its final value in IDLE until the next start.
- abort in RUN: next cycle FSM=IDLE, busy=0, sclk=cpol, strobes=0, done=0; edge_cnt holds. If abort and an edge event coincide, abort wins.
- start while busy: ignored. start and abort together in IDLE: start ignored.
- Changes to clk_div, char_len or cpha during RUN have no effect until the next start. cpol is re-sampled in IDLE only.
- presetn asserted mid-character: all outputs return to reset values immediately (asynchronous).

Decomposition:
- spi_pkg: typedef enum {IDLE, RUN} for the FSM state; the spi_mode_t struct {cpol, cpha}; the function that saturates char_len.
- Sub-module spi_clk_div: the DIV_W prescaler. Inputs are clear and en; output is a tick when the count equals the latched divide value. It reuses the existing counter conventions.
- The edge counter and strobe mapping stay in the top module.

Test Plan:
- Mode 0, clk_div=0, char_len=8, start at cycle 0 -> busy=1 at cycle 1; sclk toggles every cycle from cycle 2; 8 sample_stb on edges 1,3..15; 7 shift_stb; done at edge 16; sclk ends at 0.
- Mode 3 (cpol=1, cpha=1), clk_div=3, char_len=4 -> idle sclk=1; half-period of 4 cycles; shift_stb on edges 1,3,5,7; sample_stb on edges 2,4,6,8; done with edge_cnt=8 and sclk=1.
- char_len=0 and char_len=MAX_LEN+5 -> both run 2*MAX_LEN=64 edges; edge_cnt=64 at done.
- abort issued at edge 5 of an 8-bit character -> next cycle busy=0, sclk=cpol, no done, edge_cnt=5; a new start then clears edge_cnt and restarts cleanly.
- start pulsed mid-character and clk_div changed from 1 to 7 mid-character -> no effect on the current run; the next run uses the new divider.
- presetn dropped mid-run for 1 cycle -> sclk=0, busy=0, edge_cnt=0 immediately; the block idles until start.
